// File: rtl/child_result_collector.sv
`default_nettype none
// ============================================================================
// Module      : child_result_collector
// Description : Round-robin fan-in of N_CHILD valid/ready result streams into
//               one registered stream tagged with the source child index.
// Revision    : 1.0  initial release
// ============================================================================
module child_result_collector #(
   parameter int N_CHILD = 10,
   parameter int DATA_W  = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [N_CHILD-1:0]          in_valid,
   input  logic [N_CHILD*DATA_W-1:0]   in_data,
   output logic [N_CHILD-1:0]          in_ready,
   output logic                        out_valid,
   output logic [DATA_W-1:0]           out_data,
   output logic [3:0]                  out_idx,
   input  logic                        out_ready,
   output logic [15:0]                 xfer_cnt
);

   localparam logic [3:0] c_last_init = 4'(N_CHILD - 1);

   logic [3:0]        r_last_ptr;
   logic              w_load_en;
   logic              w_found;
   logic              w_in_xfer;
   logic [3:0]        w_grant;
   logic [4:0]        w_cand;
   logic [DATA_W-1:0] w_sel_data;

   // Candidate index walks last_ptr+1 .. last_ptr+N_CHILD, folded back into range.
   always_comb begin
      w_found = 1'b0;
      w_grant = '0;
      w_cand  = '0;
      for (int k = 0; k < N_CHILD; k++) begin
         w_cand = {1'b0, r_last_ptr} + 5'd1 + 5'(k);
         if (w_cand >= 5'(N_CHILD))
            w_cand = w_cand - 5'(N_CHILD);
         if (!w_found && in_valid[w_cand[3:0]]) begin
            w_found = 1'b1;
            w_grant = w_cand[3:0];
         end
      end
   end

   assign w_load_en  = !out_valid || out_ready;
   assign w_in_xfer  = rst_n && w_load_en && w_found;
   assign w_sel_data = in_data[int'(w_grant)*DATA_W +: DATA_W];

   always_comb begin
      in_ready = '0;
      if (w_in_xfer)
         in_ready[w_grant] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_idx    <= '0;
         xfer_cnt   <= '0;
         r_last_ptr <= c_last_init;
      end else begin
         if (out_valid && out_ready)
            xfer_cnt <= xfer_cnt + 16'd1;
         // A new grant replaces the entry even while it is being drained.
         if (w_in_xfer) begin
            out_valid  <= 1'b1;
            out_data   <= w_sel_data;
            out_idx    <= w_grant;
            r_last_ptr <= w_grant;
         end else if (out_ready) begin
            out_valid  <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/child_result_collector.md
CHILD_RESULT_COLLECTOR -- requirements
Module: child_result_collector

Interface
REQ-001 Parameter: N_CHILD, default 10, number of child instance result ports (2..16).
REQ-002 Parameter: DATA_W, default 16, width of one child result word.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  N_CHILD  per-child result valid.
REQ-006 Port: in_data  input  N_CHILD*DATA_W  child i data in bits [i*DATA_W +: DATA_W].
REQ-007 Port: in_ready  output  N_CHILD  per-child accept; one-hot or zero.
REQ-008 Port: out_valid  output  1  collected result valid.
REQ-009 Port: out_data  output  DATA_W  collected result word.
REQ-010 Port: out_idx  output  4  index of the child that produced out_data.
REQ-011 Port: out_ready  input  1  downstream accept.
REQ-012 Port: xfer_cnt  output  16  count of results delivered downstream.

Function
REQ-013 Block SHALL be the fan-in counterpart of the N_CHILD-way instance fan-out: it merges N_CHILD valid/ready result streams into one tagged stream.
REQ-014 Input transfer on child i SHALL occur when in_valid[i] and in_ready[i] are both high at a rising edge; output transfer SHALL occur when out_valid and out_ready are both high.
REQ-015 Output stage SHALL be a single registered entry; load_en = !out_valid | out_ready.
REQ-016 in_ready[i] SHALL be high only when load_en is high and child i is the current grant; at most one bit high per cycle.
REQ-017 Grant SHALL be round-robin: search starts at (last_ptr+1) mod N_CHILD, wraps past N_CHILD-1 to 0, picks the first child with in_valid high.
REQ-018 last_ptr SHALL update to the granted index only on an input transfer; it SHALL NOT move when load_en is low or no child is valid.
REQ-019 On input transfer from child i, next cycle SHALL present out_valid=1, out_data=child i data, out_idx=i (latency 1 cycle).
REQ-020 Simultaneous output transfer and input transfer in one cycle SHALL replace the entry with no bubble (full throughput, one result per cycle).
REQ-021 Output transfer without input transfer SHALL clear out_valid next cycle.
REQ-022 While out_valid=1 and out_ready=0, out_data and out_idx SHALL hold stable and all in_ready SHALL be 0.
REQ-023 in_data of a non-granted child SHALL never affect outputs.
REQ-024 xfer_cnt SHALL increment by 1 on each output transfer and wrap from 16'hFFFF to 0.
REQ-025 in_ready SHALL depend combinationally on in_valid, out_valid, out_ready and registered state only; no other combinational path to outputs.
REQ-026 A child deasserting in_valid before grant SHALL simply be skipped; no result is fabricated.

Reset
REQ-027 While rst_n=0: out_valid=0, out_data=0, out_idx=0, xfer_cnt=0, in_ready=0, last_ptr=N_CHILD-1 (so first search starts at child 0).
REQ-028 Reset asserted mid-transfer SHALL discard the held entry immediately; no transfer is counted for that cycle.
REQ-029 First grant SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-030 All 10 children valid, out_ready=1 continuously -> out_idx sequence 0,1,...,9,0,1 on consecutive cycles; xfer_cnt=10 after the tenth delivery.
REQ-031 Only child 7 valid, data 16'hA5A5, out_ready=1 -> in_ready=10'b0010000000 one cycle, then out_valid=1, out_data=16'hA5A5, out_idx=7.
REQ-032 Entry held, out_ready=0 for 5 cycles with children 2 and 3 valid -> outputs stable, in_ready=0 all 5 cycles; on release, child after the held index granted in the same cycle, no bubble.
REQ-033 last_ptr=9, children 0 and 9 valid -> child 0 granted (wrap), then child 9.
REQ-034 Preload xfer_cnt to 16'hFFFF via 65535 transfers, one more transfer -> xfer_cnt=0.
REQ-035 rst_n pulled low while out_valid=1, out_ready=0 -> out_valid=0, xfer_cnt=0 asynchronously; after release child 0 has first priority.
